// File: rtl/pkg_mult.sv
// Shared types and constants for the multiplier datapath and its result display.
package pkg_mult;

  localparam int MULT_DW = 8;

  typedef logic [2*MULT_DW-1:0] product_t;
  typedef logic [3:0]           bcd_t;
  typedef logic [6:0]           seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } disp_state_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_ZERO  = 7'h40;

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to an active-low gfedcba seven-segment pattern.
module bcd_to_seg
  import pkg_mult::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Converts the multiplier product to BCD by sequential double-dabble (one bit per
// clock) and drives leading-zero-blanked active-low seven-segment digits.
module result_display
  import pkg_mult::*;
#(
  parameter int DW = 8,
  parameter int ND = 5
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [2*DW-1:0]   i_product,
  output logic              o_ready,
  output logic              o_done,
  output logic [4*ND-1:0]   o_bcd,
  output logic [7*ND-1:0]   o_seg
);

  localparam int PW = 2*DW;
  localparam int CW = $clog2(PW+1);

  disp_state_t     r_state;
  logic [PW-1:0]   r_sr;
  logic [4*ND-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_done;
  logic [4*ND-1:0] r_bcd;
  logic [7*ND-1:0] r_seg;

  logic [4*ND-1:0] w_acc_adj;
  logic [7*ND-1:0] w_seg_raw;
  logic [7*ND-1:0] w_seg;

  // 5..9 + 3 lands in 8..12, so a 4-bit add never overflows for legal digits.
  function automatic bcd_t add3(input bcd_t d);
    return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
  endfunction

  always_comb begin
    w_acc_adj = '0;
    for (int k = 0; k < ND; k++) begin
      w_acc_adj[4*k +: 4] = add3(r_acc[4*k +: 4]);
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_dig
    bcd_to_seg u_enc (
      .i_bcd (r_acc[4*g +: 4]),
      .o_seg (w_seg_raw[7*g +: 7])
    );
  end

  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    logic hi_zero;
    w_seg   = w_seg_raw;
    hi_zero = 1'b1;
    for (int k = ND-1; k >= 1; k--) begin
      hi_zero = hi_zero && (r_acc[4*k +: 4] == 4'd0);
      if (hi_zero) w_seg[7*k +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_seg   <= {{(ND-1){SEG_BLANK}}, SEG_ZERO};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_sr    <= i_product;
            r_acc   <= '0;
            r_cnt   <= CW'(PW);
            r_ready <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= {w_acc_adj[4*ND-2:0], r_sr[PW-1]};
          r_sr  <= {r_sr[PW-2:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_acc;
          r_seg   <= w_seg;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_bcd   = r_bcd;
  assign o_seg   = r_seg;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display against a decimal-arithmetic reference.
module tb_result_display;

  localparam int DW = 8;
  localparam int ND = 5;
  localparam int PW = 2*DW;
  localparam logic [7*ND-1:0] SEG_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [PW-1:0]   product;
  logic            ready;
  logic            done;
  logic [4*ND-1:0] bcd;
  logic [7*ND-1:0] seg;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  result_display #(.DW(DW), .ND(ND)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_product (product),
    .o_ready   (ready),
    .o_done    (done),
    .o_bcd     (bcd),
    .o_seg     (seg)
  );

  function automatic logic [4*ND-1:0] ref_bcd(input int v);
    logic [4*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*ND-1:0] ref_seg(input int v);
    logic [7*ND-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      if (k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                r[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [PW-1:0] v);
    product = v;
    valid   = 1'b1;
    tick();
    valid   = 1'b0;
  endtask

  // Returns the number of edges after the accept edge at which o_done is first seen, or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; product = '0;
    tick(); tick();
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_total++; if (bcd !== '0) $display("FAIL reset_bcd got=%h exp=0", bcd); else n_pass++;
    n_total++; if (seg !== SEG_RST) $display("FAIL reset_seg got=%h exp=%h", seg, SEG_RST); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat;
    start(16'd0);
    wait_done(lat);
    n_total++; if (lat !== 17) $display("FAIL zero_latency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bcd !== 20'h00000) $display("FAIL zero_bcd got=%h exp=00000", bcd); else n_pass++;
    n_total++; if (seg !== SEG_RST) $display("FAIL zero_seg got=%h exp=%h", seg, SEG_RST); else n_pass++;
  endtask

  task automatic test_square_max();
    int lat;
    logic [7*ND-1:0] exp_s;
    exp_s = {7'h02, 7'h12, 7'h40, 7'h24, 7'h12};
    start(16'd65025);
    wait_done(lat);
    n_total++; if (lat !== 17) $display("FAIL sq_latency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bcd !== 20'h65025) $display("FAIL sq_bcd got=%h exp=65025", bcd); else n_pass++;
    n_total++; if (seg !== exp_s) $display("FAIL sq_seg got=%h exp=%h", seg, exp_s); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (done !== 1'b0) $display("FAIL sq_done_pulse got=%0b exp=0", done); else n_pass++;
    n_total++; if (bcd !== 20'h65025 || seg !== exp_s)
      $display("FAIL sq_hold got=%h/%h exp=65025/%h", bcd, seg, exp_s); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    start(16'hFFFF);
    wait_done(lat);
    n_total++; if (bcd !== 20'h65535) $display("FAIL b2b_max_bcd got=%h exp=65535", bcd); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL b2b_ready got=%0b exp=1", ready); else n_pass++;
    start(16'd7);
    wait_done(lat);
    n_total++; if (lat !== 17) $display("FAIL b2b_latency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bcd !== 20'h00007) $display("FAIL b2b_bcd got=%h exp=00007", bcd); else n_pass++;
    n_total++; if (seg !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78})
      $display("FAIL b2b_seg got=%h exp=%h", seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int lat;
    bit ready_bad;
    lat = -1;
    ready_bad = 1'b0;
    start(16'd12345);
    for (int i = 1; i <= 40; i++) begin
      valid   = (i == 3 || i == 10);
      product = valid ? 16'd999 : 16'd12345;
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (i <= 16 && ready !== 1'b0) ready_bad = 1'b1;
    end
    valid = 1'b0;
    n_total++; if (ready_bad) $display("FAIL busy_ready got=1 exp=0"); else n_pass++;
    n_total++; if (lat !== 17) $display("FAIL busy_latency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bcd !== 20'h12345) $display("FAIL busy_bcd got=%h exp=12345", bcd); else n_pass++;
    tick(); tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [4*ND-1:0] prev_bcd;
    logic [7*ND-1:0] exp_s;
    exp_s = {7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40};
    prev_bcd = bcd;
    start(16'd500);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    n_total++; if (ready !== 1'b1) $display("FAIL abort_ready got=%0b exp=1", ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_done got=%0b exp=0", done); else n_pass++;
    n_total++; if (bcd !== '0) $display("FAIL abort_bcd got=%h exp=0 (was %h)", bcd, prev_bcd); else n_pass++;
    n_total++; if (seg !== SEG_RST) $display("FAIL abort_seg got=%h exp=%h", seg, SEG_RST); else n_pass++;
    rst = 1'b0;
    start(16'd500);
    wait_done(lat);
    n_total++; if (lat !== 17) $display("FAIL abort_relatency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bcd !== 20'h00500) $display("FAIL abort_bcd500 got=%h exp=00500", bcd); else n_pass++;
    n_total++; if (seg !== exp_s) $display("FAIL abort_seg500 got=%h exp=%h", seg, exp_s); else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int v;
    for (int n = 0; n < 8; n++) begin
      v = (n == 0) ? 10 : int'($urandom_range(0, 65535));
      if (n == 1) v = int'($urandom_range(0, 99));
      start(PW'(v));
      wait_done(lat);
      n_total++; if (lat !== 17) $display("FAIL rand_latency v=%0d got=%0d exp=17", v, lat); else n_pass++;
      n_total++; if (bcd !== ref_bcd(v)) $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); else n_pass++;
      n_total++; if (seg !== ref_seg(v)) $display("FAIL rand_seg v=%0d got=%h exp=%h", v, seg, ref_seg(v)); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    product = '0;
    test_reset();
    test_zero();
    test_square_max();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
